instr_cache_line_fetch: RTL and testbench
=========================================

// Module: instr_cache_line_fetch
// PURPOSE
//  Memory-side refill engine for the L0 instruction cache. On a cache miss it fetches one full line
//  from the 32-bit instruction memory port, one word per req/gnt/rvalid transaction. It assembles
//  RAM_WIDTH bits and returns the line to the cache datapath with its tag and a one-cycle valid pulse.
//  It is the producer for the cache's new-data/tag/line interface.
// PARAMETERS
//  RAM_WIDTH   128  cache line width in bits; multiple of 32, >= 64
//  MEM_WIDTH   32   memory data width in bits; fixed at 32, other values are illegal
// PORTS
//  clk           in   1              clock, all logic on rising edge
//  rst           in   1              synchronous active-high reset
//  soft_rst_i    in   1              abort current refill (cache flush)
//  miss_req_i    in   1              cache requests a line fill; sampled only in IDLE
//  miss_addr_i   in   32             byte address of missing instruction
//  busy_o        out  1              engine not in IDLE
//  mem_req_o     out  1              memory request; held until mem_gnt_i
//  mem_addr_o    out  32             word-aligned memory address
//  mem_gnt_i     in   1              memory accepted request
//  mem_rvalid_i  in   1              read data valid (one per granted request)
//  mem_rdata_i   in   32             read data
//  line_valid_o  out  1              one-cycle pulse: line_data_o/line_tag_o valid
//  line_data_o   out  RAM_WIDTH      assembled line, word k at bits [32k+31:32k]
//  line_tag_o    out  TAG_W          line tag = miss_addr[31:LOG2_WPL+2], TAG_W = 30-LOG2_WPL
// BEHAVIOUR
//  - WPL = RAM_WIDTH/32 words per line; LOG2_WPL = $clog2(WPL); word counter wraps mod WPL.
//  - Reset: state=IDLE; busy_o, mem_req_o and line_valid_o = 0; mem_addr_o, line_data_o and line_tag_o = 0.
//  - FSM IDLE->REQ->WAIT->(REQ|DONE)->IDLE; ABORT drains outstanding data.
//  - IDLE: if miss_req_i, latch tag and start word (see CONFIGURATION); cnt=0; go to REQ.
//  - REQ: mem_req_o=1, mem_addr_o={tag, word_idx, 2'b00}; stay until mem_gnt_i, then WAIT.
//  - WAIT: on mem_rvalid_i, write mem_rdata_i into line word word_idx; increment cnt and word_idx.
//    If cnt==WPL-1, go to DONE; otherwise go to REQ.
//  - At most one transaction outstanding; mem_rvalid_i outside WAIT/ABORT is ignored.
//  - DONE: line_valid_o=1 for exactly this cycle; line_data_o/line_tag_o stable; next IDLE.
//  - line_data_o/line_tag_o hold their value until the next refill writes them.
//  - Latency with gnt same-cycle and rvalid next cycle: miss sampled in cycle 0, line_valid_o in cycle 2*WPL+1.
//  - Zero-wait back-to-back: miss_req_i high in the cycle after DONE is accepted; no bubble beyond IDLE.
//  - miss_req_i while busy_o=1 is ignored; the cache must hold or re-issue it.
//  - soft_rst_i handling:
//    - in IDLE/DONE: go to IDLE; a line_valid_o pulse already in DONE still completes.
//    - in REQ before gnt: drop mem_req_o, go to IDLE.
//    - in REQ with gnt in the same cycle, or in WAIT: go to ABORT.
//  - ABORT: no requests issued; on mem_rvalid_i, discard data and go to IDLE. line_valid_o never fires.
//  - soft_rst_i and miss_req_i in the same IDLE cycle: soft_rst_i wins and the miss is dropped.
//  - rst mid-operation: immediate return to reset values; bus protocol recovery is the system's concern.
// CONFIGURATION
//  INSTR_CACHE_CWF_EN (critical-word-first):
//   - defined: start word_idx = miss_addr_i[LOG2_WPL+1:2]; wrap through the line, e.g. words 2,3,0,1.
//   - undefined: start word_idx = 0; linear order 0..WPL-1.
//   - Line layout and line_valid_o timing are identical in both modes.
// STRUCTURE
//  - instr_cache_pkg holds: fetch_state_e enum {IDLE, REQ, WAIT, DONE, ABORT};
//    function tag_w(ram_width) = 30-$clog2(ram_width/32); localparam WORD_W = 32.
//  - Single module; no sub-module. The line buffer is a flat register written by word index.
// TESTING
//  1. RAM_WIDTH=128, miss_addr=0x0000_1008, gnt immediate, rvalid+1 -> mem_addr 0x1000,0x1004,0x1008,0x100C;
//     line_valid_o in cycle 9; line_tag=0x100.
//  2. CWF_EN, same miss -> mem_addr order 0x1008,0x100C,0x1000,0x1004; line word2 = first rdata.
//  3. gnt withheld 3 cycles on word 1 -> mem_req_o and mem_addr_o stable for those cycles; line still correct.
//  4. soft_rst_i in WAIT of word 2 -> ABORT, no new mem_req_o; after rvalid go IDLE, line_valid_o stays 0.
//  5. miss_req_i pulsed while busy, then a second miss the cycle after DONE -> first extra miss ignored;
//     second refill starts immediately.
//  6. rst asserted mid-refill -> next cycle all outputs at reset values, busy_o=0.

Source files
------------

// File: rtl/instr_cache_pkg.sv
// Shared types and constants for the L0 instruction-cache line refill engine.
package instr_cache_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      ABORT = 3'd4
   } fetch_state_e;

   function automatic int tag_w(input int ram_width);
      return 30 - $clog2(ram_width / WORD_W);
   endfunction

endpackage

// File: rtl/instr_cache_line_fetch.sv
// Refill engine: fetches one cache line word-by-word over a req/gnt/rvalid port.
// Optional critical-word-first ordering is enabled by defining INSTR_CACHE_CWF_EN.
module instr_cache_line_fetch
   import instr_cache_pkg::*;
#(
   parameter int RAM_WIDTH = 128,
   parameter int MEM_WIDTH = 32,
   localparam int WPL      = RAM_WIDTH / WORD_W,
   localparam int LOG2_WPL = $clog2(WPL),
   localparam int TAG_W    = tag_w(RAM_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 soft_rst_i,
   input  logic                 miss_req_i,
   input  logic [31:0]          miss_addr_i,
   output logic                 busy_o,
   output logic                 mem_req_o,
   output logic [31:0]          mem_addr_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [MEM_WIDTH-1:0] mem_rdata_i,
   output logic                 line_valid_o,
   output logic [RAM_WIDTH-1:0] line_data_o,
   output logic [TAG_W-1:0]     line_tag_o
);

   localparam logic [LOG2_WPL-1:0] LAST_IDX = LOG2_WPL'(WPL - 1);

   fetch_state_e          state_q;
   logic                  busy_q, req_q, valid_q;
   logic [31:0]           addr_q;
   logic [RAM_WIDTH-1:0]  data_q;
   logic [TAG_W-1:0]      tag_q, line_tag_q;
   logic [LOG2_WPL-1:0]   idx_q, cnt_q;

   logic [TAG_W-1:0]      miss_tag_d;
   logic [LOG2_WPL-1:0]   start_idx_d, next_idx_d;
   logic                  unused_addr;

   assign miss_tag_d  = miss_addr_i[31:LOG2_WPL+2];
   assign unused_addr = ^miss_addr_i[LOG2_WPL+1:0];
`ifdef INSTR_CACHE_CWF_EN
   assign start_idx_d = miss_addr_i[LOG2_WPL+1:2];
`else
   assign start_idx_d = '0;
`endif
   // Word index wraps explicitly so non-power-of-two line sizes stay in range.
   assign next_idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         tag_q      <= '0;
         line_tag_q <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (miss_req_i && !soft_rst_i) begin
                  tag_q   <= miss_tag_d;
                  idx_q   <= start_idx_d;
                  cnt_q   <= '0;
                  req_q   <= 1'b1;
                  addr_q  <= {miss_tag_d, start_idx_d, 2'b00};
                  busy_q  <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  req_q   <= 1'b0;
                  state_q <= soft_rst_i ? ABORT : WAIT;
               end else if (soft_rst_i) begin
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (mem_rvalid_i) begin
                  // Flush landing on the data beat: the transaction is already drained.
                  if (soft_rst_i) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     data_q[int'(idx_q)*WORD_W +: WORD_W] <= mem_rdata_i;
                     idx_q <= next_idx_d;
                     cnt_q <= cnt_q + 1'b1;
                     if (cnt_q == LAST_IDX) begin
                        line_tag_q <= tag_q;
                        valid_q    <= 1'b1;
                        state_q    <= DONE;
                     end else begin
                        req_q   <= 1'b1;
                        addr_q  <= {tag_q, next_idx_d, 2'b00};
                        state_q <= REQ;
                     end
                  end
               end else if (soft_rst_i) begin
                  state_q <= ABORT;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            ABORT: begin
               if (mem_rvalid_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign mem_req_o    = req_q;
   assign mem_addr_o   = addr_q;
   assign line_valid_o = valid_q;
   assign line_data_o  = data_q;
   assign line_tag_o   = line_tag_q;

endmodule

// File: tb/tb_instr_cache_line_fetch.sv
// Directed bench for instr_cache_line_fetch (RAM_WIDTH=128); follows INSTR_CACHE_CWF_EN if defined.
module tb_instr_cache_line_fetch;
   localparam int RAM_WIDTH = 128;
   localparam int TAG_W     = 28;

   logic                 clk = 1'b0;
   logic                 rst, soft_rst_i, miss_req_i, mem_gnt_i, mem_rvalid_i;
   logic [31:0]          miss_addr_i, mem_rdata_i, mem_addr_o;
   logic                 busy_o, mem_req_o, line_valid_o;
   logic [RAM_WIDTH-1:0] line_data_o;
   logic [TAG_W-1:0]     line_tag_o;

   int checks = 0;
   int failures = 0;

   logic [31:0] seen_addr [8];
   int          n_seen, valid_cycle, valid_cnt, req_after_abort;
   bit          stall_stable;

`ifdef INSTR_CACHE_CWF_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   instr_cache_line_fetch #(.RAM_WIDTH(RAM_WIDTH), .MEM_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .soft_rst_i(soft_rst_i), .miss_req_i(miss_req_i),
      .miss_addr_i(miss_addr_i), .busy_o(busy_o), .mem_req_o(mem_req_o),
      .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .line_valid_o(line_valid_o),
      .line_data_o(line_data_o), .line_tag_o(line_tag_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected address of the k-th request for a miss at addr (4-word line).
   function automatic logic [31:0] exp_addr(input logic [31:0] addr, input int k);
      int s;
      s = CWF ? int'(addr[3:2]) : 0;
      return {addr[31:4], 4'h0} + 32'(((s + k) % 4) * 4);
   endfunction

   function automatic logic [RAM_WIDTH-1:0] exp_line(input logic [31:0] addr);
      logic [31:0] base;
      base = {addr[31:4], 4'h0};
      return {32'hA000_0000 | (base + 32'd12), 32'hA000_0000 | (base + 32'd8),
              32'hA000_0000 | (base + 32'd4),  32'hA000_0000 | base};
   endfunction

   // Memory-side driver: grants, returns data (0xA000_0000|addr) one cycle after grant,
   // optionally stalls a grant, injects a flush, or pulses a spurious miss. Records only.
   task automatic serve(input logic [31:0] addr, input int stall_word, input int stall_n,
                        input int abort_word, input int extra_miss_cyc, input int max_cyc);
      int cyc, w, st;
      bit pend, in_req, aborted;
      logic [31:0] a0, pend_addr;
      n_seen = 0; valid_cycle = -1; valid_cnt = 0; req_after_abort = 0; stall_stable = 1'b1;
      w = 0; st = 0; pend = 0; in_req = 0; aborted = 0; a0 = '0; pend_addr = '0;
      miss_req_i = 1'b1; miss_addr_i = addr;
      tick();
      cyc = 1;
      miss_req_i = 1'b0;
      while (cyc < max_cyc) begin
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; soft_rst_i = 1'b0; miss_req_i = 1'b0;
         if (cyc == extra_miss_cyc) begin miss_req_i = 1'b1; miss_addr_i = 32'h0000_5000; end
         if (line_valid_o) begin
            valid_cnt++;
            if (valid_cycle < 0) valid_cycle = cyc;
         end
         if (aborted && mem_req_o) req_after_abort++;
         if (pend) begin
            if (w == abort_word && !aborted) begin
               soft_rst_i = 1'b1; aborted = 1'b1;
            end else begin
               mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA000_0000 | pend_addr; pend = 0; w++;
            end
         end else if (mem_req_o && !aborted) begin
            if (!in_req) begin
               in_req = 1'b1; a0 = mem_addr_o;
               if (n_seen < 8) seen_addr[n_seen] = a0;
               n_seen++;
            end else if (mem_addr_o !== a0) stall_stable = 1'b0;
            if (w == stall_word && st < stall_n) st++;
            else begin mem_gnt_i = 1'b1; pend = 1; pend_addr = mem_addr_o; in_req = 0; end
         end
         tick();
         cyc++;
         if (valid_cnt > 0) break;
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; soft_rst_i = 1'b0; miss_req_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; soft_rst_i = 0; miss_req_i = 0; miss_addr_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      repeat (3) tick();
      checks++;
      if ({busy_o, mem_req_o, line_valid_o} !== 3'b000) begin
         failures++; $display("FAIL reset_ctrl got=%b want=000", {busy_o, mem_req_o, line_valid_o});
      end
      checks++;
      if (mem_addr_o !== 32'h0 || line_data_o !== '0 || line_tag_o !== '0) begin
         failures++; $display("FAIL reset_data addr=%h tag=%h data=%h want zeros", mem_addr_o, line_tag_o, line_data_o);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_refill();
      serve(32'h0000_1008, -1, 0, -1, -1, 40);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (seen_addr[k] !== exp_addr(32'h0000_1008, k)) begin
            failures++; $display("FAIL basic_addr%0d got=%h want=%h", k, seen_addr[k], exp_addr(32'h0000_1008, k));
         end
      end
      checks++;
      if (valid_cycle != 9 || valid_cnt != 1) begin
         failures++; $display("FAIL basic_latency cycle=%0d pulses=%0d want cycle=9 pulses=1", valid_cycle, valid_cnt);
      end
      checks++;
      if (line_data_o !== exp_line(32'h0000_1008)) begin
         failures++; $display("FAIL basic_data got=%h want=%h", line_data_o, exp_line(32'h0000_1008));
      end
      checks++;
      if (line_tag_o !== 28'h100) begin
         failures++; $display("FAIL basic_tag got=%h want=100", line_tag_o);
      end
      checks++;
      if (busy_o !== 1'b0 || line_valid_o !== 1'b0) begin
         failures++; $display("FAIL basic_idle busy=%b valid=%b want 0 0", busy_o, line_valid_o);
      end
   endtask

   task automatic test_gnt_stall();
      serve(32'h0000_2004, 1, 3, -1, -1, 40);
      checks++;
      if (!stall_stable || n_seen != 4) begin
         failures++; $display("FAIL stall_stable stable=%0d reqs=%0d want 1 4", stall_stable, n_seen);
      end
      checks++;
      if (seen_addr[1] !== exp_addr(32'h0000_2004, 1)) begin
         failures++; $display("FAIL stall_addr got=%h want=%h", seen_addr[1], exp_addr(32'h0000_2004, 1));
      end
      checks++;
      if (valid_cycle != 12 || line_data_o !== exp_line(32'h0000_2004) || line_tag_o !== 28'h200) begin
         failures++; $display("FAIL stall_line cycle=%0d tag=%h data=%h want 12 200 %h",
                              valid_cycle, line_tag_o, line_data_o, exp_line(32'h0000_2004));
      end
   endtask

   task automatic test_abort();
      serve(32'h0000_3000, -1, 0, 2, -1, 20);
      checks++;
      if (valid_cnt != 0 || req_after_abort != 0) begin
         failures++; $display("FAIL abort_quiet pulses=%0d reqs=%0d want 0 0", valid_cnt, req_after_abort);
      end
      checks++;
      if (n_seen != 3 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
         failures++; $display("FAIL abort_idle reqs=%0d busy=%b req=%b want 3 0 0", n_seen, busy_o, mem_req_o);
      end
   endtask

   task automatic test_soft_rst_idle_req();
      miss_req_i = 1'b1; soft_rst_i = 1'b1; miss_addr_i = 32'h0000_6000;
      tick();
      miss_req_i = 1'b0; soft_rst_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
         failures++; $display("FAIL softrst_idle busy=%b req=%b want 0 0", busy_o, mem_req_o);
      end
      miss_req_i = 1'b1;
      tick();
      miss_req_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== exp_addr(32'h0000_6000, 0)) begin
         failures++; $display("FAIL softrst_start busy=%b req=%b addr=%h want 1 1 %h",
                              busy_o, mem_req_o, mem_addr_o, exp_addr(32'h0000_6000, 0));
      end
      soft_rst_i = 1'b1;
      tick();
      soft_rst_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
         failures++; $display("FAIL softrst_req busy=%b req=%b want 0 0", busy_o, mem_req_o);
      end
   endtask

   task automatic test_back_to_back();
      serve(32'h0000_4000, -1, 0, -1, 3, 40);
      checks++;
      if (n_seen != 4 || seen_addr[3][31:4] !== 28'h400 || line_tag_o !== 28'h400) begin
         failures++; $display("FAIL b2b_ignore reqs=%0d last=%h tag=%h want 4 0x400x 400", n_seen, seen_addr[3], line_tag_o);
      end
      serve(32'h0000_7000, -1, 0, -1, -1, 40);
      checks++;
      if (valid_cycle != 9 || seen_addr[0] !== 32'h0000_7000) begin
         failures++; $display("FAIL b2b_second cycle=%0d addr0=%h want 9 00007000", valid_cycle, seen_addr[0]);
      end
      checks++;
      if (line_data_o !== exp_line(32'h0000_7000) || line_tag_o !== 28'h700) begin
         failures++; $display("FAIL b2b_data tag=%h data=%h want 700 %h", line_tag_o, line_data_o, exp_line(32'h0000_7000));
      end
   endtask

   task automatic test_hard_reset();
      miss_req_i = 1'b1; miss_addr_i = 32'h0000_8000;
      tick();
      miss_req_i = 1'b0;
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1) begin
         failures++; $display("FAIL hrst_pre busy=%b want 1", busy_o);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy_o, mem_req_o, line_valid_o} !== 3'b000 || mem_addr_o !== '0 ||
          line_data_o !== '0 || line_tag_o !== '0) begin
         failures++; $display("FAIL hrst_outputs ctrl=%b addr=%h tag=%h want zeros",
                              {busy_o, mem_req_o, line_valid_o}, mem_addr_o, line_tag_o);
      end
   endtask

   initial begin
      test_reset();
      test_basic_refill();
      test_gnt_stall();
      test_abort();
      test_soft_rst_idle_req();
      test_back_to_back();
      test_hard_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
